ddr_axi_txn_limiter: RTL and testbench
======================================

Name: ddr_axi_txn_limiter

Overview:
- Sequences the handshake channels of the external DDR AXI port, sitting between the AXI node slave port 1 and the AXI_DDR_* pins.
- Caps outstanding read and write bursts and prevents W beats from reaching DDR before their AW.
- Provides a quiesce handshake so software or clock control can drain DDR traffic before gating or reconfiguration.
- Payload fields (addr, len, id, data, resp, user) bypass this block; only valid/ready/last are routed through it.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts per direction (1..15)
CNT_WIDTH, 4, width of outstanding counters; must hold MAX_OUTSTANDING
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with DDR_WDOG_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_aw_valid / s_aw_ready  in/out  1  AW handshake, node side
s_w_valid / s_w_ready / s_w_last  in/out/in  1  W handshake, node side
s_b_valid / s_b_ready  out/in  1  B handshake, node side
s_ar_valid / s_ar_ready  in/out  1  AR handshake, node side
s_r_valid / s_r_ready / s_r_last  out/in/out  1  R handshake, node side
m_aw_valid / m_aw_ready  out/in  1  AW handshake, DDR side
m_w_valid / m_w_ready / m_w_last  out/in/out  1  W handshake, DDR side
m_b_valid / m_b_ready  in/out  1  B handshake, DDR side
m_ar_valid / m_ar_ready  out/in  1  AR handshake, DDR side
m_r_valid / m_r_ready / m_r_last  in/out/in  1  R handshake, DDR side
quiesce_req_i  in  1  level request to drain and block new bursts
quiesce_ack_o  out  1  high while drained and blocked
wr_outstanding_o  out  CNT_WIDTH  write bursts awaiting B
rd_outstanding_o  out  CNT_WIDTH  read bursts awaiting last R
busy_o  out  1  any counter nonzero
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n), and takes effect immediately on assertion.
- Reset values: all counters 0; FSM=RUN; quiesce_ack_o=0; timeout_o=0; hold flags 0.
- All m_* valid and s_* ready outputs are 0 during reset.
- Reset mid-burst drops all tracking; no recovery.
- B/R channels are pure combinational pass-through: s_b_valid=m_b_valid, m_b_ready=s_b_ready, and the same for R valid/ready/last.
- aw_allow = (FSM==RUN) and wr_cnt<MAX_OUTSTANDING; or aw_hold.
  - m_aw_valid = s_aw_valid & aw_allow; s_aw_ready = m_aw_ready & aw_allow.
- aw_hold: set when m_aw_valid=1 and m_aw_ready=0; cleared on AW handshake. This keeps valid stable per AXI even if quiesce arrives or the limit changes.
- AR path is identical with rd_cnt and ar_hold.
- wr_cnt: +1 on AW handshake, -1 on B handshake; both in the same cycle means unchanged.
- rd_cnt: +1 on AR handshake, -1 on R handshake with r_last; both in the same cycle means unchanged.
- w_credit (CNT_WIDTH): +1 on AW handshake, -1 on W handshake with w_last; simultaneous means unchanged.
  - m_w_valid = s_w_valid & (w_credit!=0); s_w_ready = m_w_ready & (w_credit!=0).
  - W is never forwarded in the same cycle as its own AW handshake (credit is registered).
- Counter underflow (B or last-R with count 0) is a protocol error: the count saturates at 0. Simulation assertion only.
- FSM:
  - RUN→DRAIN on quiesce_req_i=1.
  - DRAIN→QUIET when wr_cnt=0, rd_cnt=0, w_credit=0, aw_hold=0, ar_hold=0.
  - DRAIN→RUN if quiesce_req_i drops before drained.
  - QUIET→RUN on quiesce_req_i=0.
  - quiesce_ack_o is registered and equals 1 exactly in QUIET.
  - If already idle, quiesce_ack_o rises 2 cycles after quiesce_req_i rises.
- wr_outstanding_o=wr_cnt, rd_outstanding_o=rd_cnt, busy_o=(wr_cnt|rd_cnt|w_credit)!=0. All registered.

Optional Feature:
- Macro DDR_WDOG_EN.
- Defined:
  - A watchdog counter runs while busy_o=1 and no B handshake or last-R handshake occurs.
  - It clears on any such handshake, or when busy_o=0.
  - timeout_o is set when the counter reaches TIMEOUT_CYCLES-1, and stays set until reset.
  - On timeout the FSM is forced to DRAIN, blocking new AW/AR until quiesce_req_i is cycled 1→0.
- Undefined: timeout_o tied 0 and no watchdog logic.

Test Plan:
- Issue 6 back-to-back AW, m_aw_ready=1, B withheld → 4 forwarded; 5th stalls with s_aw_ready=0 and wr_outstanding_o=4; one B releases exactly one AW.
- W presented 3 cycles before its AW → m_w_valid stays 0 until the cycle after the AW handshake; 4-beat burst forwarded; w_credit returns to 0 after w_last.
- m_aw_valid pending with m_aw_ready=0 when quiesce_req_i rises → m_aw_valid held until ready; B returns; quiesce_ack_o=1; new AR blocked until quiesce_req_i=0.
- Same-cycle AW handshake and B handshake at wr_cnt=2 → wr_cnt stays 2; same-cycle AR and last-R → rd_cnt unchanged.
- Idle, quiesce_req_i 0→1 → quiesce_ack_o=1 two cycles later; release → ack 0 next cycle, traffic resumes.
- With DDR_WDOG_EN and TIMEOUT_CYCLES=16: 1 read outstanding, no R for 16 cycles → timeout_o=1; subsequent AR blocked; assert rst_n low → all outputs return to reset values.

Source files
------------

// File: rtl/ddr_axi_txn_limiter.sv
// Handshake sequencer for the external DDR AXI port: outstanding-burst caps, W-after-AW ordering, quiesce drain.
// Optional watchdog enabled by defining DDR_WDOG_EN.
module ddr_axi_txn_limiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_aw_valid,
    output logic                 s_aw_ready,
    input  logic                 s_w_valid,
    output logic                 s_w_ready,
    input  logic                 s_w_last,
    output logic                 s_b_valid,
    input  logic                 s_b_ready,
    input  logic                 s_ar_valid,
    output logic                 s_ar_ready,
    output logic                 s_r_valid,
    input  logic                 s_r_ready,
    output logic                 s_r_last,
    output logic                 m_aw_valid,
    input  logic                 m_aw_ready,
    output logic                 m_w_valid,
    input  logic                 m_w_ready,
    output logic                 m_w_last,
    input  logic                 m_b_valid,
    output logic                 m_b_ready,
    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    input  logic                 m_r_valid,
    output logic                 m_r_ready,
    input  logic                 m_r_last,
    input  logic                 quiesce_req_i,
    output logic                 quiesce_ack_o,
    output logic [CNT_WIDTH-1:0] wr_outstanding_o,
    output logic [CNT_WIDTH-1:0] rd_outstanding_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIET} state_e;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, w_credit_q, w_credit_d;
    logic                   aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
    logic                   ack_q, busy_q, busy_d;
    logic                   aw_allow, ar_allow, w_open, drained;
    logic                   aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
    logic                   wd_evt, wd_lock;

    function automatic logic [CNT_WIDTH-1:0] step_cnt(input logic [CNT_WIDTH-1:0] c,
                                                      input logic inc, input logic dec);
        if (inc && !dec) return c + CNT_WIDTH'(1);
        if (dec && !inc && c != '0) return c - CNT_WIDTH'(1);
        return c;
    endfunction

    assign s_b_valid = m_b_valid;
    assign m_b_ready = s_b_ready;
    assign s_r_valid = m_r_valid;
    assign m_r_ready = s_r_ready;
    assign s_r_last  = m_r_last;
    assign m_w_last  = s_w_last;

    // A pending address keeps its grant (hold) so valid never drops before ready.
    assign aw_allow   = rst_n & (((state_q == ST_RUN) & (wr_cnt_q < MAX_CNT)) | aw_hold_q);
    assign ar_allow   = rst_n & (((state_q == ST_RUN) & (rd_cnt_q < MAX_CNT)) | ar_hold_q);
    assign w_open     = (w_credit_q != '0);

    assign m_aw_valid = s_aw_valid & aw_allow;
    assign s_aw_ready = m_aw_ready & aw_allow;
    assign m_ar_valid = s_ar_valid & ar_allow;
    assign s_ar_ready = m_ar_ready & ar_allow;
    assign m_w_valid  = s_w_valid & w_open;
    assign s_w_ready  = m_w_ready & w_open;

    assign aw_hs      = m_aw_valid & m_aw_ready;
    assign w_last_hs  = m_w_valid & m_w_ready & s_w_last;
    assign b_hs       = m_b_valid & s_b_ready;
    assign ar_hs      = m_ar_valid & m_ar_ready;
    assign r_last_hs  = m_r_valid & s_r_ready & m_r_last;

    assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_credit_q == '0)
                     && !aw_hold_q && !ar_hold_q;

    always_comb begin
        wr_cnt_d   = step_cnt(wr_cnt_q, aw_hs, b_hs);
        rd_cnt_d   = step_cnt(rd_cnt_q, ar_hs, r_last_hs);
        w_credit_d = step_cnt(w_credit_q, aw_hs, w_last_hs);
        aw_hold_d  = m_aw_valid & ~m_aw_ready;
        ar_hold_d  = m_ar_valid & ~m_ar_ready;
        busy_d     = (wr_cnt_d | rd_cnt_d | w_credit_d) != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            w_credit_q <= '0;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            w_credit_q <= w_credit_d;
            aw_hold_q  <= aw_hold_d;
            ar_hold_q  <= ar_hold_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (quiesce_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!quiesce_req_i && !wd_lock)     state_d = ST_RUN;
                else if (quiesce_req_i && drained)  state_d = ST_QUIET;
            end
            ST_QUIET: if (!quiesce_req_i && !wd_lock) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (wd_evt) state_d = ST_DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ST_QUIET);
        end
    end

`ifdef DDR_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d, lock_q, lock_d, seen_q, seen_d;

    assign wd_evt  = !timeout_q && (wdog_q == WD_LIMIT);
    assign wd_lock = lock_q;

    // After a timeout, new bursts stay blocked until quiesce_req_i is seen high and then low.
    always_comb begin
        wdog_d    = wdog_q;
        if (!busy_q || b_hs || r_last_hs) wdog_d = '0;
        else if (wdog_q != WD_LIMIT)      wdog_d = wdog_q + WD_W'(1);
        timeout_d = timeout_q | wd_evt;
        lock_d    = lock_q;
        seen_d    = seen_q;
        if (wd_evt) begin
            lock_d = 1'b1;
            seen_d = 1'b0;
        end else if (lock_q && quiesce_req_i) begin
            seen_d = 1'b1;
        end else if (lock_q && seen_q) begin
            lock_d = 1'b0;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            lock_q    <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            lock_q    <= lock_d;
            seen_q    <= seen_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wd_evt    = 1'b0;
    assign wd_lock   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign quiesce_ack_o    = ack_q;
    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;
    assign busy_o           = busy_q;

    // Response with nothing outstanding is a protocol error; counters saturate at zero.
    a_no_b_underflow: assert property (@(posedge clk) disable iff (!rst_n) b_hs |-> wr_cnt_q != '0);
    a_no_r_underflow: assert property (@(posedge clk) disable iff (!rst_n) r_last_hs |-> rd_cnt_q != '0);

endmodule

// File: tb/tb_ddr_axi_txn_limiter.sv
// Directed bench for ddr_axi_txn_limiter: per-cycle compare against a burst-level model plus literal checkpoints.
module tb_ddr_axi_txn_limiter;
  localparam int MAXO = 4;
  localparam int CW   = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last, s_b_valid, s_b_ready;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
  logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
  logic quiesce_req_i, quiesce_ack_o, busy_o, timeout_o;
  logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;

  int n_vec  = 0;
  int n_fail = 0;

  ddr_axi_txn_limiter #(.MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .quiesce_req_i(quiesce_req_i), .quiesce_ack_o(quiesce_ack_o),
    .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: burst counts, grant holds, quiesce mode (0 run, 1 draining, 2 quiet).
  int m_wr, m_rd, m_cr, m_mode, m_wd, m_lock, nmode;
  bit m_haw, m_har, m_ack, m_to;
  bit aw_ok, ar_ok, w_ok, e_awv, e_awr, e_arv, e_arr, e_wv, e_wr;
  bit awh, wlh, bh, arh, rlh, m_busy, m_drained, evt;
  int aw_seen = 0, w_seen = 0, ar_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wr = 0; m_rd = 0; m_cr = 0; m_mode = 0; m_wd = 0; m_lock = 0;
      m_haw = 0; m_har = 0; m_ack = 0; m_to = 0;
      chk("rst_m_aw_valid", m_aw_valid, 0);
      chk("rst_s_aw_ready", s_aw_ready, 0);
      chk("rst_m_ar_valid", m_ar_valid, 0);
      chk("rst_s_ar_ready", s_ar_ready, 0);
      chk("rst_m_w_valid",  m_w_valid, 0);
      chk("rst_s_w_ready",  s_w_ready, 0);
      chk("rst_ack",        quiesce_ack_o, 0);
      chk("rst_wr_out",     wr_outstanding_o, 0);
      chk("rst_rd_out",     rd_outstanding_o, 0);
      chk("rst_busy",       busy_o, 0);
      chk("rst_timeout",    timeout_o, 0);
    end else begin
      m_busy = (m_wr != 0) || (m_rd != 0) || (m_cr != 0);
      aw_ok  = m_haw || (m_mode == 0 && m_wr < MAXO);
      ar_ok  = m_har || (m_mode == 0 && m_rd < MAXO);
      w_ok   = (m_cr > 0);
      e_awv = s_aw_valid && aw_ok;  e_awr = m_aw_ready && aw_ok;
      e_arv = s_ar_valid && ar_ok;  e_arr = m_ar_ready && ar_ok;
      e_wv  = s_w_valid && w_ok;    e_wr  = m_w_ready && w_ok;
      chk("m_aw_valid", m_aw_valid, e_awv);
      chk("s_aw_ready", s_aw_ready, e_awr);
      chk("m_ar_valid", m_ar_valid, e_arv);
      chk("s_ar_ready", s_ar_ready, e_arr);
      chk("m_w_valid",  m_w_valid, e_wv);
      chk("s_w_ready",  s_w_ready, e_wr);
      chk("m_w_last",   m_w_last, s_w_last);
      chk("s_b_valid",  s_b_valid, m_b_valid);
      chk("m_b_ready",  m_b_ready, s_b_ready);
      chk("s_r_valid",  s_r_valid, m_r_valid);
      chk("m_r_ready",  m_r_ready, s_r_ready);
      chk("s_r_last",   s_r_last, m_r_last);
      chk("wr_out",     wr_outstanding_o, m_wr);
      chk("rd_out",     rd_outstanding_o, m_rd);
      chk("busy",       busy_o, m_busy);
      chk("ack",        quiesce_ack_o, m_ack);
      chk("timeout",    timeout_o, m_to);

      aw_seen += (s_aw_valid && s_aw_ready) ? 1 : 0;
      w_seen  += (m_w_valid && m_w_ready && m_w_last) ? 1 : 0;
      ar_seen += (s_ar_valid && s_ar_ready) ? 1 : 0;

      awh = e_awv && m_aw_ready;
      wlh = e_wv && m_w_ready && s_w_last;
      bh  = m_b_valid && s_b_ready;
      arh = e_arv && m_ar_ready;
      rlh = m_r_valid && s_r_ready && m_r_last;
      m_drained = (m_wr == 0) && (m_rd == 0) && (m_cr == 0) && !m_haw && !m_har;

`ifdef DDR_WDOG_EN
      evt = !m_to && (m_wd == TO - 1);
      if (!m_busy || bh || rlh) m_wd = 0; else m_wd++;
`else
      evt = 0;
`endif
      nmode = m_mode;
      case (m_mode)
        0: if (quiesce_req_i) nmode = 1;
        1: if (!quiesce_req_i && m_lock == 0) nmode = 0;
           else if (quiesce_req_i && m_drained) nmode = 2;
        default: if (!quiesce_req_i && m_lock == 0) nmode = 0;
      endcase
      if (evt) begin
        nmode = 1; m_to = 1; m_lock = 1;
      end else if (m_lock == 1 && quiesce_req_i) m_lock = 2;
      else if (m_lock == 2 && !quiesce_req_i) m_lock = 0;
      m_mode = nmode;
      m_ack  = (nmode == 2);

      m_haw = e_awv && !m_aw_ready;
      m_har = e_arv && !m_ar_ready;
      m_wr = m_wr + int'(awh) - int'(bh);  if (m_wr < 0) m_wr = 0;
      m_rd = m_rd + int'(arh) - int'(rlh); if (m_rd < 0) m_rd = 0;
      m_cr = m_cr + int'(awh) - int'(wlh); if (m_cr < 0) m_cr = 0;
    end
  end

  int base;

  initial begin
    rst_n = 0; quiesce_req_i = 0;
    s_aw_valid = 1; m_aw_ready = 1; s_ar_valid = 1; m_ar_ready = 1;
    s_w_valid = 0; s_w_last = 0; m_w_ready = 1; s_b_ready = 1; m_b_valid = 0;
    s_r_ready = 1; m_r_valid = 0; m_r_last = 0;
    repeat (3) tick();
    s_aw_valid = 0; s_ar_valid = 0;
    rst_n = 1;
    tick();

    // 6 back-to-back AW with B withheld: only 4 pass
    s_aw_valid = 1;
    repeat (8) tick();
    chk("t1_aw_fwd4", aw_seen, 4);
    chk("t1_wr_out4", wr_outstanding_o, 4);
    chk("t1_aw_stall", s_aw_ready, 0);
    s_w_valid = 1; s_w_last = 1;
    repeat (4) tick();
    s_w_valid = 0;
    chk("t1_w_bursts", w_seen, 4);
    m_b_valid = 1; tick(); m_b_valid = 0;
    repeat (3) tick();
    chk("t1_one_b_one_aw", aw_seen, 5);
    chk("t1_wr_out_again4", wr_outstanding_o, 4);
    s_w_valid = 1; tick(); s_w_valid = 0;
    m_b_valid = 1; tick(); m_b_valid = 0;
    tick();
    chk("t1_aw6", aw_seen, 6);
    s_aw_valid = 0;
    s_w_valid = 1; tick(); s_w_valid = 0;
    m_b_valid = 1; repeat (4) tick(); m_b_valid = 0;
    chk("t1_wr_drained", wr_outstanding_o, 0);
    chk("t1_idle", busy_o, 0);

    // W ahead of its AW
    s_w_valid = 1; s_w_last = 0;
    repeat (3) tick();
    chk("t2_w_blocked", m_w_valid, 0);
    s_aw_valid = 1; #1;
    chk("t2_aw_fwd", m_aw_valid, 1);
    chk("t2_w_not_same_cycle", m_w_valid, 0);
    tick();
    s_aw_valid = 0; #1;
    chk("t2_w_open", m_w_valid, 1);
    for (int i = 0; i < 4; i++) begin
      s_w_last = (i == 3);
      tick();
    end
    s_w_last = 0; #1;
    chk("t2_credit_spent", m_w_valid, 0);
    chk("t2_busy_wr", busy_o, 1);
    s_w_valid = 0;
    m_b_valid = 1; tick(); m_b_valid = 0;
    chk("t2_idle", busy_o, 0);

    // AW stalled by DDR when quiesce arrives
    m_aw_ready = 0; s_aw_valid = 1;
    tick();
    quiesce_req_i = 1;
    repeat (3) tick();
    chk("t3_aw_held", m_aw_valid, 1);
    chk("t3_no_ack_yet", quiesce_ack_o, 0);
    m_aw_ready = 1; tick();
    s_aw_valid = 0;
    s_w_valid = 1; s_w_last = 1; tick(); s_w_valid = 0; s_w_last = 0;
    m_b_valid = 1; tick(); m_b_valid = 0;
    repeat (3) tick();
    chk("t3_ack", quiesce_ack_o, 1);
    base = ar_seen;
    s_ar_valid = 1;
    repeat (3) tick();
    chk("t3_ar_blocked", m_ar_valid, 0);
    chk("t3_ar_none", ar_seen, base);
    quiesce_req_i = 0;
    tick();
    chk("t3_ack_drop", quiesce_ack_o, 0);
    tick();
    s_ar_valid = 0;
    chk("t3_ar_resumed", ar_seen, base + 1);
    chk("t3_rd_out1", rd_outstanding_o, 1);
    m_r_valid = 1; m_r_last = 1; tick(); m_r_valid = 0; m_r_last = 0;
    chk("t3_rd_out0", rd_outstanding_o, 0);

    // simultaneous increment and decrement
    s_aw_valid = 1; repeat (2) tick(); s_aw_valid = 0;
    chk("t4_wr2", wr_outstanding_o, 2);
    s_aw_valid = 1; m_b_valid = 1; tick(); s_aw_valid = 0; m_b_valid = 0;
    chk("t4_wr_same", wr_outstanding_o, 2);
    s_w_valid = 1; s_w_last = 1; repeat (3) tick(); s_w_valid = 0; s_w_last = 0;
    m_b_valid = 1; repeat (2) tick(); m_b_valid = 0;
    s_ar_valid = 1; tick(); s_ar_valid = 0;
    s_ar_valid = 1; m_r_valid = 1; m_r_last = 1; tick(); s_ar_valid = 0; m_r_last = 0;
    chk("t4_rd_same", rd_outstanding_o, 1);
    tick();
    chk("t4_rd_nonlast", rd_outstanding_o, 1);
    m_r_last = 1; tick(); m_r_valid = 0; m_r_last = 0;
    chk("t4_rd0", rd_outstanding_o, 0);
    chk("t4_idle", busy_o, 0);

    // idle quiesce: ack two cycles after request
    quiesce_req_i = 1;
    tick();
    chk("t5_ack_c1", quiesce_ack_o, 0);
    tick();
    chk("t5_ack_c2", quiesce_ack_o, 1);
    quiesce_req_i = 0;
    tick();
    chk("t5_ack_release", quiesce_ack_o, 0);
    base = aw_seen;
    s_aw_valid = 1; tick(); s_aw_valid = 0;
    chk("t5_traffic", aw_seen, base + 1);
    s_w_valid = 1; s_w_last = 1; tick(); s_w_valid = 0; s_w_last = 0;
    m_b_valid = 1; tick(); m_b_valid = 0;

    // read left hanging
    s_ar_valid = 1; tick(); s_ar_valid = 0;
`ifdef DDR_WDOG_EN
    repeat (TO - 1) tick();
    chk("t6_no_timeout_yet", timeout_o, 0);
    tick();
    chk("t6_timeout", timeout_o, 1);
    s_ar_valid = 1;
    repeat (3) tick();
    chk("t6_ar_blocked", m_ar_valid, 0);
    chk("t6_rd_out1", rd_outstanding_o, 1);
    rst_n = 0; #1;
    chk("t6_rst_timeout", timeout_o, 0);
    chk("t6_rst_rd", rd_outstanding_o, 0);
    chk("t6_rst_ar_valid", m_ar_valid, 0);
    chk("t6_rst_ar_ready", s_ar_ready, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ack", quiesce_ack_o, 0);
    tick();
    s_ar_valid = 0;
    rst_n = 1;
    tick();
`else
    repeat (TO + 4) tick();
    chk("t6_no_wdog", timeout_o, 0);
    chk("t6_rd_still1", rd_outstanding_o, 1);
    m_r_valid = 1; m_r_last = 1; tick(); m_r_valid = 0; m_r_last = 0;
`endif
    repeat (3) tick();
    chk("end_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
